// File: rtl/start_detector.sv
// Serial start-pattern detector with a downstream handshake: it hunts for PATTERN,
// pulses w_seq, then waits up to TMO cycles for busy before flagging a timeout.
module start_detector #(
  parameter int unsigned     PLEN    = 4,
  parameter logic [PLEN-1:0] PATTERN = 4'b1101,
  parameter int unsigned     TMO     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  input  logic       busy,
  output logic       w_seq,
  output logic       hunting,
  output logic       timeout_err,
  output logic [7:0] det_count
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    HIT   = 2'd1,
    WAIT  = 2'd2,
    BLOCK = 2'd3
  } state_t;

  localparam logic [3:0] FILL_MAX = 4'(PLEN);
  localparam logic [3:0] FILL_ARM = 4'(PLEN - 1);
  localparam logic [3:0] TMR_LAST = 4'(TMO - 1);

  state_t          state;
  logic [PLEN-1:0] sr;
  logic [3:0]      fill;
  logic [3:0]      timer;
  logic [PLEN-1:0] shifted;
  logic            match;

  assign shifted = {sr[PLEN-2:0], ser_in};
  // The current bit completes the window only once PLEN-1 earlier bits were collected.
  assign match   = (fill >= FILL_ARM) && (shifted == PATTERN);

  assign w_seq   = (state == HIT);
  assign hunting = (state == HUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      sr          <= '0;
      fill        <= '0;
      timer       <= '0;
      det_count   <= '0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      case (state)
        HUNT: begin
          if (!busy) begin
            sr <= shifted;
            if (fill != FILL_MAX) fill <= fill + 4'd1;
            if (match) begin
              state <= HIT;
              if (det_count != 8'hFF) det_count <= det_count + 8'd1;
            end
          end
        end
        HIT: begin
          state <= WAIT;
          timer <= '0;
        end
        WAIT: begin
          if (busy) begin
            state <= BLOCK;
          end else if (timer == TMR_LAST) begin
            state       <= HUNT;
            timeout_err <= 1'b1;
            sr          <= '0;
            fill        <= '0;
          end else begin
            timer <= timer + 4'd1;
          end
        end
        BLOCK: begin
          if (!busy) begin
            state <= HUNT;
            sr    <= '0;
            fill  <= '0;
          end
        end
        default: begin
          state <= HUNT;
          sr    <= '0;
          fill  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_start_detector.sv
// Directed bench for start_detector with default parameters (PLEN=4, PATTERN=1101, TMO=4).
module tb_start_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser_in;
  logic       busy;
  logic       w_seq;
  logic       hunting;
  logic       timeout_err;
  logic [7:0] det_count;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  start_detector dut (
    .clk        (clk),
    .rst        (rst),
    .ser_in     (ser_in),
    .busy       (busy),
    .w_seq      (w_seq),
    .hunting    (hunting),
    .timeout_err(timeout_err),
    .det_count  (det_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive one bit, clock it in, and sample just after the edge; counts w_seq pulses.
  task automatic tick(input logic s, input logic b);
    ser_in = s;
    busy   = b;
    @(posedge clk);
    #1;
    if (w_seq) pulses++;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    ser_in = 1'b0;
    busy   = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    pulses = 0;
  endtask

  task automatic send_pattern(input logic b);
    tick(1'b1, b);
    tick(1'b1, b);
    tick(1'b0, b);
    tick(1'b1, b);
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_hunting", 32'(hunting), 1);
    check("rst_wseq", 32'(w_seq), 0);
    check("rst_count", 32'(det_count), 0);
    check("rst_err", 32'(timeout_err), 0);

    // Basic detection: pulse only after the 4th bit
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("basic_no_early", 32'(pulses), 0);
    tick(1'b1, 1'b0);
    check("basic_wseq", 32'(w_seq), 1);
    check("basic_count", 32'(det_count), 1);
    tick(1'b0, 1'b0);  // HIT -> WAIT, timer cleared
    check("basic_wseq_one_cycle", 32'(w_seq), 0);

    // Timeout: HUNT and sticky error exactly TMO edges after WAIT entry
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("tmo_not_yet_hunting", 32'(hunting), 0);
    check("tmo_not_yet_err", 32'(timeout_err), 0);
    tick(1'b0, 1'b0);
    check("tmo_hunting", 32'(hunting), 1);
    check("tmo_err", 32'(timeout_err), 1);
    // Fresh pattern after timeout detects again; error stays set
    send_pattern(1'b0);
    check("tmo_redetect", 32'(w_seq), 1);
    check("tmo_count2", 32'(det_count), 2);
    check("tmo_err_sticky", 32'(timeout_err), 1);

    // No overlap: 1101101, busy rises one cycle after the pulse, held 10 cycles
    do_reset();
    send_pattern(1'b0);
    tick(1'b1, 1'b0);  // w_seq cycle, busy still 0
    tick(1'b0, 1'b1);  // WAIT sees busy -> BLOCK
    check("blk_state", 32'(dut.state), 3);
    check("blk_hunting", 32'(hunting), 0);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1);
    check("blk_still", 32'(dut.state), 3);
    tick(1'b0, 1'b0);
    check("blk_release_hunting", 32'(hunting), 1);
    check("blk_one_pulse", 32'(pulses), 1);
    check("blk_count", 32'(det_count), 1);
    check("blk_no_err", 32'(timeout_err), 0);

    // busy=1 in HUNT freezes the shifter; detection resumes after it drops
    do_reset();
    send_pattern(1'b1);
    check("hold_no_pulse", 32'(pulses), 0);
    check("hold_hunting", 32'(hunting), 1);
    send_pattern(1'b0);
    check("hold_then_detect", 32'(w_seq), 1);
    check("hold_count", 32'(det_count), 1);

    // busy arrives on the final timer edge: BLOCK wins, no error
    do_reset();
    send_pattern(1'b0);
    tick(1'b0, 1'b0);  // enter WAIT
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);  // timer at TMO-1 with busy
    check("prio_state", 32'(dut.state), 3);
    check("prio_no_err", 32'(timeout_err), 0);
    tick(1'b0, 1'b0);
    check("prio_back_hunting", 32'(hunting), 1);

    // Asynchronous reset while in WAIT, then a partial pattern
    do_reset();
    send_pattern(1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("arst_pre_wait", 32'(dut.state), 2);
    rst = 1'b1;
    #1;
    check("arst_hunting", 32'(hunting), 1);
    check("arst_wseq", 32'(w_seq), 0);
    check("arst_count", 32'(det_count), 0);
    check("arst_err", 32'(timeout_err), 0);
    #2;
    rst    = 1'b0;
    pulses = 0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check("arst_partial_no_pulse", 32'(pulses), 0);
    check("arst_partial_hunting", 32'(hunting), 1);

    // 260 back-to-back frames: counter saturates at 255
    do_reset();
    for (int f = 0; f < 260; f++) begin
      send_pattern(1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      if (f == 0)   check("sat_first", 32'(det_count), 1);
      if (f == 254) check("sat_at_255", 32'(det_count), 255);
    end
    check("sat_final", 32'(det_count), 255);
    check("sat_pulses", 32'(pulses), 260);
    check("sat_no_err", 32'(timeout_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/start_detector.md
START_DETECTOR -- requirements
Module: start_detector

Interface
REQ-001 The block SHALL have parameter PLEN, default 4, giving the start-pattern length in bits (legal range 2..8).
REQ-002 The block SHALL have parameter PATTERN, default 4'b1101, giving the start pattern; the first serial bit received is compared against PATTERN[PLEN-1].
REQ-003 The block SHALL have parameter TMO, default 4, giving the maximum cycles to wait for busy after a detection (legal range 1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port ser_in, input, 1 bit: serial data stream, one bit sampled per clk.
REQ-007 The block SHALL have port busy, input, 1 bit: downstream transfer controller is outside its idle state.
REQ-008 The block SHALL have port w_seq, output, 1 bit: one-cycle start-pattern-found pulse to the downstream controller.
REQ-009 The block SHALL have port hunting, output, 1 bit: high while the block is searching for a pattern.
REQ-010 The block SHALL have port timeout_err, output, 1 bit: sticky flag, set when downstream fails to acknowledge a detection.
REQ-011 The block SHALL have port det_count, output, 8 bits: number of detections since reset.

Function
REQ-012 The FSM SHALL have four states, HUNT, HIT, WAIT and BLOCK; w_seq = (state==HIT) and hunting = (state==HUNT), both Moore.
REQ-013 HUNT with busy=0: each edge shifts sr <= {sr[PLEN-2:0], ser_in} and increments fill, saturating at PLEN.
REQ-014 HUNT with busy=1: sr and fill hold, and no detection is made.
REQ-015 HUNT -> HIT on an edge where busy=0, fill >= PLEN-1 and {sr[PLEN-2:0], ser_in} == PATTERN; w_seq is high for exactly the cycle after the edge that samples the last pattern bit.
REQ-016 Overlapping patterns SHALL NOT be detected: a new match requires PLEN fresh bits after returning to HUNT.
REQ-017 On the edge entering HIT, det_count SHALL increment by 1, saturating at 255 (no wrap).
REQ-018 HIT -> WAIT unconditionally after one cycle, with the wait timer cleared to 0.
REQ-019 WAIT: if busy=1, go to BLOCK; otherwise increment the timer, and when the timer reaches TMO-1 go to HUNT and set timeout_err.
REQ-020 If busy=1 in the same cycle the timer reaches TMO-1, BLOCK SHALL take priority and timeout_err is not set.
REQ-021 BLOCK: stay while busy=1; go to HUNT on the first edge with busy=0.
REQ-022 Every entry to HUNT SHALL clear sr and fill to 0.
REQ-023 timeout_err SHALL be cleared only by rst.
REQ-024 Unreachable state encodings SHALL go to HUNT on the next edge.

Reset
REQ-025 rst=1 SHALL immediately force state=HUNT, sr=0, fill=0, timer=0, det_count=0 and timeout_err=0, so that w_seq=0 and hunting=1, regardless of clk.
REQ-026 rst asserted mid-frame (in HIT, WAIT or BLOCK) SHALL abandon the frame; after release, detection needs PLEN fresh bits.

Verification
REQ-027 Defaults; rst released, ser_in=1,1,0,1, busy=0 -> w_seq high only in the cycle after the 4th bit; det_count=1.
REQ-028 ser_in=1,1,0,1,1,0,1 with busy rising 1 cycle after w_seq and held 10 cycles -> one pulse only, state BLOCK while busy=1, hunting=1 after busy falls; det_count=1.
REQ-029 Pattern received, busy stays 0 -> hunting=1 and timeout_err=1 exactly TMO cycles after the WAIT entry; timeout_err persists until rst.
REQ-030 busy=1 held while ser_in carries 1101 in HUNT -> no w_seq; busy drops, 1101 sent again -> w_seq pulse.
REQ-031 rst pulsed while in WAIT -> outputs return immediately to REQ-025 values; a partial pattern 1,0,1 after release gives no w_seq.
REQ-032 260 back-to-back frames, each pattern followed by a 2-cycle busy pulse -> det_count saturates at 255.
